// File: rtl/aib_axil_bridge_master.sv
// AXI4-Lite slave side of an AIB bridge: packs AR/AW/W into 80-bit tx words, unpacks R/B rx words.
// Optional macro AIB_AXIL_PARITY_EN: generate tx parity in [75] and discard rx words with bad parity.
module aib_axil_bridge_master #(
  parameter int AW    = 32,
  parameter int DW    = 32,
  parameter int OUTST = 4
) (
  input  logic            clk_wr,
  input  logic            rst_wr_n,
  input  logic            fs_mac_rdy,
  input  logic [15:0]     delay_x_value,
  input  logic [7:0]      init_ar_credit,
  input  logic [7:0]      init_aw_credit,
  input  logic [7:0]      init_w_credit,
  input  logic [AW-1:0]   awaddr,
  input  logic            awvalid,
  output logic            awready,
  input  logic [DW-1:0]   wdata,
  input  logic [DW/8-1:0] wstrb,
  input  logic            wvalid,
  output logic            wready,
  output logic [1:0]      bresp,
  output logic            bvalid,
  input  logic            bready,
  input  logic [AW-1:0]   araddr,
  input  logic            arvalid,
  output logic            arready,
  output logic [DW-1:0]   rdata,
  output logic [1:0]      rresp,
  output logic            rvalid,
  input  logic            rready,
  output logic [79:0]     tx_data,
  input  logic [79:0]     rx_data,
  output logic [31:0]     tx_ar_debug_status,
  output logic [31:0]     tx_aw_debug_status,
  output logic [31:0]     tx_w_debug_status,
  output logic [31:0]     rx_r_debug_status,
  output logic [31:0]     rx_b_debug_status
);
  localparam int CW = $clog2(OUTST + 1);
  localparam int PW = (OUTST > 1) ? $clog2(OUTST) : 1;
  localparam logic [2:0] T_AR = 3'b001, T_AW = 3'b010, T_W = 3'b011;
  localparam logic [2:0] T_R = 3'b100, T_B = 3'b101, T_CR = 3'b110;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(OUTST - 1)) ? '0 : p + PW'(1);
  endfunction

  logic [15:0] rdy_cnt_q;
  logic        tx_en_q;
  logic        load_q;

  always_ff @(posedge clk_wr or negedge rst_wr_n) begin
    if (!rst_wr_n) begin
      rdy_cnt_q <= '0;
      tx_en_q   <= 1'b0;
      load_q    <= 1'b1;
    end else begin
      load_q <= 1'b0;
      if (!fs_mac_rdy) begin
        rdy_cnt_q <= '0;
        tx_en_q   <= 1'b0;
      end else begin
        if (rdy_cnt_q != 16'hFFFF) rdy_cnt_q <= rdy_cnt_q + 16'd1;
        tx_en_q <= ({1'b0, rdy_cnt_q} + 17'd1) >= {1'b0, delay_x_value};
      end
    end
  end

  // Receive decode; a bad-parity word is only ever counted, never acted on.
  logic [2:0] rx_type;
  logic       rx_par_ok, rx_good, rx_bad;
  logic       r_word, b_word, cr_word;
  logic       unused_rx;
  assign rx_type = rx_data[78:76];
`ifdef AIB_AXIL_PARITY_EN
  assign rx_par_ok = ((^{rx_data[78:76], rx_data[74:0]}) == rx_data[75]);
`else
  assign rx_par_ok = 1'b1;
`endif
  assign rx_good   = rx_data[79] && rx_par_ok;
  assign rx_bad    = rx_data[79] && !rx_par_ok;
  assign r_word    = rx_good && (rx_type == T_R);
  assign b_word    = rx_good && (rx_type == T_B);
  assign cr_word   = rx_good && (rx_type == T_CR);
  assign unused_rx = ^{rx_data[74:DW+2], rx_data[75]};

  logic [CW-1:0] r_cnt_q, b_cnt_q, rd_outst_q, wr_outst_q, w_pend_q;
  logic          r_push, b_push, r_pop, b_pop;
  logic [2:0]    send, cr_ret;
  logic [2:0][7:0]  credit;
  logic [2:0][23:0] sent_cnt;
  logic [2:0][7:0]  init_credit;

  assign init_credit = {init_w_credit, init_aw_credit, init_ar_credit};
  assign cr_ret      = cr_word ? rx_data[2:0] : 3'b000;

  // A response is only accepted while some outstanding request has no queued answer yet.
  assign r_push = r_word && (r_cnt_q < rd_outst_q);
  assign b_push = b_word && (b_cnt_q < wr_outst_q);
  assign r_pop  = rvalid && rready;
  assign b_pop  = bvalid && bready;

  logic aw_elig, w_elig, ar_elig;
  assign aw_elig = awvalid && tx_en_q && (credit[1] != 8'd0) && (wr_outst_q < CW'(OUTST));
  assign w_elig  = wvalid && tx_en_q && (credit[2] != 8'd0) && (w_pend_q != '0);
  assign ar_elig = arvalid && tx_en_q && (credit[0] != 8'd0) && (rd_outst_q < CW'(OUTST));
  assign awready = aw_elig;
  assign wready  = w_elig && !aw_elig;
  assign arready = ar_elig && !aw_elig && !w_elig;
  assign send    = {wvalid && wready, awvalid && awready, arvalid && arready};

  logic [79:0] tx_data_q, tx_data_d;
  always_comb begin
    logic [2:0]  t;
    logic [74:0] p;
    logic        par;
    t = 3'b000;
    p = '0;
    tx_data_d = '0;
    if (send[1]) begin
      t = T_AW;
      p = 75'(awaddr);
    end else if (send[2]) begin
      t = T_W;
      p = 75'({wstrb, wdata});
    end else if (send[0]) begin
      t = T_AR;
      p = 75'(araddr);
    end
`ifdef AIB_AXIL_PARITY_EN
    par = ^{t, p};
`else
    par = 1'b0;
`endif
    if (send != 3'b000) tx_data_d = {1'b1, t, par, p};
  end

  for (genvar gi = 0; gi < 3; gi++) begin : g_credit
    logic [7:0]  credit_q, credit_d;
    logic [23:0] sent_q;
    always_comb begin
      credit_d = credit_q;
      if (load_q) credit_d = init_credit[gi];
      else if (send[gi] && !cr_ret[gi]) credit_d = credit_q - 8'd1;
      else if (cr_ret[gi] && !send[gi] && credit_q != 8'hFF) credit_d = credit_q + 8'd1;
    end
    always_ff @(posedge clk_wr or negedge rst_wr_n) begin
      if (!rst_wr_n) begin
        credit_q <= '0;
        sent_q   <= '0;
      end else begin
        credit_q <= credit_d;
        if (send[gi]) sent_q <= sent_q + 24'd1;
      end
    end
    assign credit[gi]   = credit_q;
    assign sent_cnt[gi] = sent_q;
  end

  logic [DW+1:0] r_mem [OUTST];
  logic [1:0]    b_mem [OUTST];
  logic [PW-1:0] r_wp_q, r_rp_q, b_wp_q, b_rp_q;
  logic [7:0]    r_err_q, b_err_q;
  logic [15:0]   r_rx_q, b_rx_q;
  logic          r_err_inc, b_err_inc;

  assign r_err_inc = (r_word && !r_push) || (rx_bad && rx_type != T_B && rx_type != T_CR);
  assign b_err_inc = (b_word && !b_push) || (rx_bad && (rx_type == T_B || rx_type == T_CR));

  always_ff @(posedge clk_wr) begin
    if (r_push) r_mem[r_wp_q] <= {rx_data[DW+1:DW], rx_data[DW-1:0]};
    if (b_push) b_mem[b_wp_q] <= rx_data[1:0];
  end

  always_ff @(posedge clk_wr or negedge rst_wr_n) begin
    if (!rst_wr_n) begin
      tx_data_q  <= '0;
      r_wp_q     <= '0;
      r_rp_q     <= '0;
      b_wp_q     <= '0;
      b_rp_q     <= '0;
      r_cnt_q    <= '0;
      b_cnt_q    <= '0;
      rd_outst_q <= '0;
      wr_outst_q <= '0;
      w_pend_q   <= '0;
      r_err_q    <= '0;
      b_err_q    <= '0;
      r_rx_q     <= '0;
      b_rx_q     <= '0;
    end else begin
      tx_data_q  <= tx_data_d;
      if (r_push) r_wp_q <= ptr_inc(r_wp_q);
      if (r_pop)  r_rp_q <= ptr_inc(r_rp_q);
      if (b_push) b_wp_q <= ptr_inc(b_wp_q);
      if (b_pop)  b_rp_q <= ptr_inc(b_rp_q);
      r_cnt_q    <= r_cnt_q + CW'(r_push) - CW'(r_pop);
      b_cnt_q    <= b_cnt_q + CW'(b_push) - CW'(b_pop);
      rd_outst_q <= rd_outst_q + CW'(send[0]) - CW'(r_pop);
      wr_outst_q <= wr_outst_q + CW'(send[1]) - CW'(b_pop);
      w_pend_q   <= w_pend_q + CW'(send[1]) - CW'(send[2]);
      if (r_err_inc && r_err_q != 8'hFF) r_err_q <= r_err_q + 8'd1;
      if (b_err_inc && b_err_q != 8'hFF) b_err_q <= b_err_q + 8'd1;
      if (r_word) r_rx_q <= r_rx_q + 16'd1;
      if (b_word) b_rx_q <= b_rx_q + 16'd1;
    end
  end

  assign tx_data = tx_data_q;
  assign rvalid  = (r_cnt_q != '0);
  assign bvalid  = (b_cnt_q != '0);
  assign {rresp, rdata} = rvalid ? r_mem[r_rp_q] : '0;
  assign bresp          = bvalid ? b_mem[b_rp_q] : 2'b00;

  assign tx_ar_debug_status = {credit[0], sent_cnt[0]};
  assign tx_aw_debug_status = {credit[1], sent_cnt[1]};
  assign tx_w_debug_status  = {credit[2], sent_cnt[2]};
  assign rx_r_debug_status  = {8'(r_cnt_q), r_err_q, r_rx_q};
  assign rx_b_debug_status  = {8'(b_cnt_q), b_err_q, b_rx_q};
endmodule

// File: tb/tb_aib_axil_bridge_master.sv
// Self-checking bench for aib_axil_bridge_master: directed scenarios plus a randomized
// transaction mix compared against a queue/counter model of the bridge.
module tb_aib_axil_bridge_master;
  logic        clk_wr = 1'b0;
  logic        rst_wr_n = 1'b0;
  logic        fs_mac_rdy = 1'b0;
  logic [15:0] delay_x_value = '0;
  logic [7:0]  init_ar_credit = '0, init_aw_credit = '0, init_w_credit = '0;
  logic [31:0] awaddr = '0, araddr = '0, wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        awvalid = 1'b0, wvalid = 1'b0, arvalid = 1'b0, bready = 1'b0, rready = 1'b0;
  logic        awready, wready, arready, bvalid, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;
  logic [79:0] tx_data, rx_data = '0;
  logic [31:0] st_ar, st_aw, st_w, st_r, st_b;

  int vectors = 0;
  int errors  = 0;
  int cred[3];
  int sent[3];
  int wr_out, rd_out, rx_r_words, rx_b_words;

  always #5 clk_wr = ~clk_wr;

  aib_axil_bridge_master #(.AW(32), .DW(32), .OUTST(4)) dut (
    .clk_wr(clk_wr), .rst_wr_n(rst_wr_n), .fs_mac_rdy(fs_mac_rdy), .delay_x_value(delay_x_value),
    .init_ar_credit(init_ar_credit), .init_aw_credit(init_aw_credit), .init_w_credit(init_w_credit),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .tx_data(tx_data), .rx_data(rx_data),
    .tx_ar_debug_status(st_ar), .tx_aw_debug_status(st_aw), .tx_w_debug_status(st_w),
    .rx_r_debug_status(st_r), .rx_b_debug_status(st_b)
  );

  function automatic logic [79:0] mk(input logic [2:0] t, input logic [74:0] p);
    logic par;
    par = 1'b0;
`ifdef AIB_AXIL_PARITY_EN
    par = ^{t, p};
`endif
    return {1'b1, t, par, p};
  endfunction

  function automatic int sat_inc(input int c);
    return (c >= 255) ? 255 : c + 1;
  endfunction

  function automatic logic rdy(input int ch);
    case (ch)
      0:       return arready;
      1:       return awready;
      default: return wready;
    endcase
  endfunction

  task automatic do_reset(input logic [7:0] iar, input logic [7:0] iaw, input logic [7:0] iw,
                          input logic [15:0] dly);
    rst_wr_n = 1'b0;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0; bready = 1'b0; rready = 1'b0; rx_data = '0;
    init_ar_credit = iar; init_aw_credit = iaw; init_w_credit = iw;
    delay_x_value = dly; fs_mac_rdy = 1'b1;
    repeat (3) @(negedge clk_wr);
    rst_wr_n = 1'b1;
    cred[0] = iar; cred[1] = iaw; cred[2] = iw;
    for (int i = 0; i < 3; i++) sent[i] = 0;
    wr_out = 0; rd_out = 0; rx_r_words = 0; rx_b_words = 0;
  endtask

  // Drives one channel (0 AR, 1 AW, 2 W) until accepted; returns the tx word seen after the edge.
  task automatic send(input int ch, input logic [31:0] v, input logic [3:0] s,
                      output logic ok, output logic [79:0] w);
    int n;
    n = 0;
    case (ch)
      0:       begin araddr = v; arvalid = 1'b1; end
      1:       begin awaddr = v; awvalid = 1'b1; end
      default: begin wdata = v; wstrb = s; wvalid = 1'b1; end
    endcase
    #1;
    while (!rdy(ch) && n < 100) begin
      @(negedge clk_wr); #1; n++;
    end
    ok = rdy(ch);
    @(negedge clk_wr);
    w = tx_data;
    case (ch)
      0:       arvalid = 1'b0;
      1:       awvalid = 1'b0;
      default: wvalid = 1'b0;
    endcase
    if (ok) begin
      cred[ch]--;
      sent[ch]++;
    end
  endtask

  task automatic inject(input logic [79:0] w);
    rx_data = w;
    @(negedge clk_wr);
    rx_data = '0;
  endtask

  task automatic test_reset();
    do_reset(8'hFF, 8'hFF, 8'hFF, 16'd0);
    #1;
    vectors++; if (tx_data !== 80'd0) begin errors++; $display("FAIL reset_tx_data got %h want 0", tx_data); end
    vectors++; if ({awready, wready, arready, bvalid, rvalid} !== 5'b0) begin
      errors++; $display("FAIL reset_handshake got %b want 00000", {awready, wready, arready, bvalid, rvalid}); end
    vectors++; if ({st_ar, st_aw, st_w, st_r, st_b} !== 160'd0) begin
      errors++; $display("FAIL reset_status got %h want 0", {st_ar, st_aw, st_w, st_r, st_b}); end
    @(posedge clk_wr); @(negedge clk_wr);
    vectors++; if ({st_ar[31:24], st_aw[31:24], st_w[31:24]} !== 24'hFFFFFF) begin
      errors++; $display("FAIL reset_credit_load got %h want ffffff", {st_ar[31:24], st_aw[31:24], st_w[31:24]}); end
    vectors++; if (tx_data !== 80'd0) begin errors++; $display("FAIL idle_tx_data got %h want 0", tx_data); end
    $display("txn reset done");
  endtask

  task automatic test_aw_w_b();
    logic ok;
    logic [79:0] w;
    send(1, 32'hA000_0000, 4'h0, ok, w);
    vectors++; if (w !== mk(3'b010, {43'd0, 32'hA000_0000}) || !ok) begin
      errors++; $display("FAIL aw_word got %h want %h", w, mk(3'b010, {43'd0, 32'hA000_0000})); end
    vectors++; if (st_aw[31:24] !== 8'hFE) begin errors++; $display("FAIL aw_credit got %h want fe", st_aw[31:24]); end
    send(2, 32'hDEAD_BEEF, 4'hF, ok, w);
    vectors++; if (w !== mk(3'b011, {39'd0, 4'hF, 32'hDEAD_BEEF}) || !ok) begin
      errors++; $display("FAIL w_word got %h want %h", w, mk(3'b011, {39'd0, 4'hF, 32'hDEAD_BEEF})); end
    vectors++; if (st_w[31:24] !== 8'hFE) begin errors++; $display("FAIL w_credit got %h want fe", st_w[31:24]); end
    wr_out++;
    inject(mk(3'b101, 75'd0));
    rx_b_words++;
    #1;
    vectors++; if ({bvalid, bresp} !== 3'b100) begin errors++; $display("FAIL b_resp got %b want 100", {bvalid, bresp}); end
    bready = 1'b1; @(negedge clk_wr); bready = 1'b0; wr_out--;
    #1;
    vectors++; if (bvalid !== 1'b0) begin errors++; $display("FAIL b_pop got %b want 0", bvalid); end
    vectors++; if (st_b !== {8'd0, 8'd0, 16'(rx_b_words)}) begin errors++; $display("FAIL b_status got %h want 1", st_b); end
    inject(mk(3'b110, 75'b110));
    cred[1] = sat_inc(cred[1]); cred[2] = sat_inc(cred[2]);
    vectors++; if ({st_aw[31:24], st_w[31:24]} !== {8'(cred[1]), 8'(cred[2])}) begin
      errors++; $display("FAIL aw_w_credit_return got %h want %h", {st_aw[31:24], st_w[31:24]}, {8'(cred[1]), 8'(cred[2])}); end
    inject(mk(3'b110, 75'b010));
    cred[1] = sat_inc(cred[1]);
    vectors++; if (st_aw !== {8'(cred[1]), 24'(sent[1])}) begin
      errors++; $display("FAIL aw_credit_saturate got %h want %h", st_aw, {8'(cred[1]), 24'(sent[1])}); end
    $display("txn aw/w/b done");
  endtask

  task automatic test_ar_r();
    logic ok;
    logic [79:0] w;
    send(0, 32'hA000_0000, 4'h0, ok, w);
    vectors++; if (w !== mk(3'b001, {43'd0, 32'hA000_0000}) || !ok) begin
      errors++; $display("FAIL ar_word got %h want %h", w, mk(3'b001, {43'd0, 32'hA000_0000})); end
    vectors++; if (st_ar[31:24] !== 8'(cred[0])) begin errors++; $display("FAIL ar_credit got %h want %h", st_ar[31:24], 8'(cred[0])); end
    inject(mk(3'b100, {41'd0, 2'b00, 32'h1234_5678}));
    #1;
    vectors++; if ({rvalid, rresp, rdata} !== {1'b1, 2'b00, 32'h1234_5678}) begin
      errors++; $display("FAIL r_data got %b_%b_%h want 1_00_12345678", rvalid, rresp, rdata); end
    rready = 1'b1; @(negedge clk_wr); rready = 1'b0;
    inject(mk(3'b110, 75'b001));
    cred[0] = sat_inc(cred[0]);
    vectors++; if (st_ar[31:24] !== 8'hFF || rvalid !== 1'b0) begin
      errors++; $display("FAIL ar_credit_return got %h/%b want ff/0", st_ar[31:24], rvalid); end
    $display("txn ar/r done");
  endtask

  task automatic test_credit_block();
    logic ok;
    logic [79:0] w;
    do_reset(8'd1, 8'hFF, 8'hFF, 16'd0);
    send(0, 32'h0000_1000, 4'h0, ok, w);
    vectors++; if (!ok || w !== mk(3'b001, {43'd0, 32'h0000_1000})) begin
      errors++; $display("FAIL ar1_word got %h want %h", w, mk(3'b001, {43'd0, 32'h0000_1000})); end
    araddr = 32'h0000_2000; arvalid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      vectors++; if (arready !== 1'b0) begin errors++; $display("FAIL ar_no_credit cycle %0d got %b want 0", i, arready); end
      @(negedge clk_wr);
    end
    inject(mk(3'b110, 75'b001));
    #1;
    vectors++; if (arready !== 1'b1) begin errors++; $display("FAIL ar_credit_unblock got %b want 1", arready); end
    @(negedge clk_wr);
    arvalid = 1'b0;
    vectors++; if (tx_data !== mk(3'b001, {43'd0, 32'h0000_2000})) begin
      errors++; $display("FAIL ar2_word got %h want %h", tx_data, mk(3'b001, {43'd0, 32'h0000_2000})); end
    vectors++; if (st_ar !== {8'd0, 24'd2}) begin errors++; $display("FAIL ar_status got %h want 00000002", st_ar); end
    $display("txn credit block done");
  endtask

  task automatic test_tx_delay();
    int  run;
    bit  got;
    do_reset(8'hFF, 8'hFF, 8'hFF, 16'd10);
    run = 0; got = 0;
    awaddr = 32'h5555_AAAA; awvalid = 1'b1;
    for (int c = 0; c < 40 && !got; c++) begin
      fs_mac_rdy = (c != 5);
      #1;
      vectors++; if (awready !== (run >= 10)) begin
        errors++; $display("FAIL tx_delay cycle %0d got %b want %b", c, awready, run >= 10); end
      if (awready) got = 1;
      @(posedge clk_wr);
      run = fs_mac_rdy ? run + 1 : 0;
      @(negedge clk_wr);
    end
    awvalid = 1'b0;
    vectors++; if (!got || tx_data !== mk(3'b010, {43'd0, 32'h5555_AAAA})) begin
      errors++; $display("FAIL tx_delay_word got %h want %h", tx_data, mk(3'b010, {43'd0, 32'h5555_AAAA})); end
    $display("txn tx delay done");
  endtask

  task automatic test_priority();
    logic ok;
    logic [79:0] w;
    logic [31:0] a1, a2, d;
    do_reset(8'hFF, 8'hFF, 8'hFF, 16'd0);
    send(1, $urandom, 4'h0, ok, w);
    a1 = $urandom; a2 = $urandom; d = $urandom;
    awaddr = a1; awvalid = 1'b1; wdata = d; wstrb = 4'h3; wvalid = 1'b1; araddr = a2; arvalid = 1'b1;
    #1;
    vectors++; if ({awready, wready, arready} !== 3'b100) begin errors++; $display("FAIL prio_aw got %b want 100", {awready, wready, arready}); end
    @(negedge clk_wr);
    awvalid = 1'b0;
    vectors++; if (tx_data !== mk(3'b010, {43'd0, a1})) begin errors++; $display("FAIL prio_aw_word got %h want %h", tx_data, mk(3'b010, {43'd0, a1})); end
    #1;
    vectors++; if ({awready, wready, arready} !== 3'b010) begin errors++; $display("FAIL prio_w got %b want 010", {awready, wready, arready}); end
    @(negedge clk_wr);
    wvalid = 1'b0;
    vectors++; if (tx_data !== mk(3'b011, {39'd0, 4'h3, d})) begin errors++; $display("FAIL prio_w_word got %h want %h", tx_data, mk(3'b011, {39'd0, 4'h3, d})); end
    #1;
    vectors++; if ({awready, wready, arready} !== 3'b001) begin errors++; $display("FAIL prio_ar got %b want 001", {awready, wready, arready}); end
    @(negedge clk_wr);
    arvalid = 1'b0;
    vectors++; if (tx_data !== mk(3'b001, {43'd0, a2})) begin errors++; $display("FAIL prio_ar_word got %h want %h", tx_data, mk(3'b001, {43'd0, a2})); end
    @(negedge clk_wr);
    vectors++; if (tx_data !== 80'd0) begin errors++; $display("FAIL prio_idle got %h want 0", tx_data); end
    $display("txn priority done");
  endtask

  task automatic test_unexpected();
    do_reset(8'hFF, 8'hFF, 8'hFF, 16'd0);
    @(negedge clk_wr);
    inject(mk(3'b101, 75'd1));
    #1;
    vectors++; if (bvalid !== 1'b0 || st_b[31:16] !== 16'h0001) begin
      errors++; $display("FAIL unexpected_b got %b/%h want 0/0001", bvalid, st_b[31:16]); end
    inject(mk(3'b100, {41'd0, 2'b10, 32'hCAFE_F00D}));
    #1;
    vectors++; if (rvalid !== 1'b0 || st_r[31:16] !== 16'h0001) begin
      errors++; $display("FAIL unexpected_r got %b/%h want 0/0001", rvalid, st_r[31:16]); end
    $display("txn unexpected done");
  endtask

  task automatic test_random();
    logic ok;
    logic [79:0] w;
    logic [31:0] a, d;
    logic [3:0]  s;
    logic [33:0] rq[$];
    logic [1:0]  bq[$];
    logic [33:0] er;
    logic [1:0]  eb;
    logic [2:0]  bits;
    int op, k;
    do_reset(8'hFF, 8'hFF, 8'hFF, 16'd0);
    for (int it = 0; it < 60; it++) begin
      op = $urandom_range(0, 4);
      if (op == 0 && wr_out < 4) begin
        a = $urandom; d = $urandom; s = 4'($urandom);
        send(1, a, 4'h0, ok, w);
        vectors++; if (!ok || w !== mk(3'b010, {43'd0, a})) begin errors++; $display("FAIL rnd_aw got %h want %h", w, mk(3'b010, {43'd0, a})); end
        send(2, d, s, ok, w);
        vectors++; if (!ok || w !== mk(3'b011, {39'd0, s, d})) begin errors++; $display("FAIL rnd_w got %h want %h", w, mk(3'b011, {39'd0, s, d})); end
        wr_out++;
        $display("txn %0d write addr %h data %h strb %h", it, a, d, s);
      end else if (op == 1 && rd_out < 4) begin
        a = $urandom;
        send(0, a, 4'h0, ok, w);
        vectors++; if (!ok || w !== mk(3'b001, {43'd0, a})) begin errors++; $display("FAIL rnd_ar got %h want %h", w, mk(3'b001, {43'd0, a})); end
        rd_out++;
        $display("txn %0d read addr %h", it, a);
      end else if (op == 2 && wr_out > 0) begin
        k = $urandom_range(1, wr_out);
        for (int i = 0; i < k; i++) begin
          eb = 2'($urandom); bq.push_back(eb); inject(mk(3'b101, {73'd0, eb})); rx_b_words++;
        end
        vectors++; if (st_b[31:24] !== 8'(k)) begin errors++; $display("FAIL rnd_b_occ got %0d want %0d", st_b[31:24], k); end
        while (bq.size() > 0) begin
          eb = bq.pop_front();
          #1;
          vectors++; if ({bvalid, bresp} !== {1'b1, eb}) begin errors++; $display("FAIL rnd_b got %b want %b", {bvalid, bresp}, {1'b1, eb}); end
          bready = 1'b1; @(negedge clk_wr); bready = 1'b0; wr_out--;
        end
        $display("txn %0d %0d write responses", it, k);
      end else if (op == 3 && rd_out > 0) begin
        k = $urandom_range(1, rd_out);
        for (int i = 0; i < k; i++) begin
          er = {2'($urandom), 32'($urandom)}; rq.push_back(er); inject(mk(3'b100, {41'd0, er})); rx_r_words++;
        end
        vectors++; if (st_r[31:24] !== 8'(k)) begin errors++; $display("FAIL rnd_r_occ got %0d want %0d", st_r[31:24], k); end
        while (rq.size() > 0) begin
          er = rq.pop_front();
          #1;
          vectors++; if ({rvalid, rresp, rdata} !== {1'b1, er}) begin errors++; $display("FAIL rnd_r got %h want %h", {rvalid, rresp, rdata}, {1'b1, er}); end
          rready = 1'b1; @(negedge clk_wr); rready = 1'b0; rd_out--;
        end
        $display("txn %0d %0d read responses", it, k);
      end else begin
        bits = 3'($urandom_range(1, 7));
        inject(mk(3'b110, {72'd0, bits}));
        for (int i = 0; i < 3; i++) if (bits[i]) cred[i] = sat_inc(cred[i]);
        $display("txn %0d credit return %b", it, bits);
      end
    end
    vectors++; if ({st_ar, st_aw, st_w} !== {8'(cred[0]), 24'(sent[0]), 8'(cred[1]), 24'(sent[1]), 8'(cred[2]), 24'(sent[2])}) begin
      errors++; $display("FAIL rnd_tx_status got %h %h %h want %h %h %h", st_ar, st_aw, st_w,
                        {8'(cred[0]), 24'(sent[0])}, {8'(cred[1]), 24'(sent[1])}, {8'(cred[2]), 24'(sent[2])}); end
    vectors++; if ({st_r[15:0], st_b[15:0]} !== {16'(rx_r_words), 16'(rx_b_words)}) begin
      errors++; $display("FAIL rnd_rx_count got %h %h want %0d %0d", st_r[15:0], st_b[15:0], rx_r_words, rx_b_words); end
  endtask

  initial begin
    test_reset();
    test_aw_w_b();
    test_ar_r();
    test_credit_block();
    test_tx_delay();
    test_priority();
    test_unexpected();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired after %0d vectors, %0d miscompares", vectors, errors);
    $fatal(1, "watchdog");
  end
endmodule
